// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: decodes loads/stores from the execute stage, runs a
// req/ack data-memory transaction with byte-lane alignment, and issues a registered writeback packet.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_data_2,
    input  logic        i_mem_rw,
    input  logic [2:0]  i_load_store_mode,
    input  logic [1:0]  i_wb_sel,
    input  logic [31:0] i_pc_inc,
    input  logic        i_reg_wr_en,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_rd,
    output logic        o_wb_reg_wr_en,
    output logic        o_access_fault,
    output logic        o_bus_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        wr_en_q;

    logic [1:0]  off;
    logic [2:0]  mode;
    logic        is_load, is_store, is_mem;
    logic        illegal_mode, misaligned, fault, good_mem;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] alu_wb_data;
    logic [31:0] load_data;
    logic        accept_good, accept_fault, accept_other;
    logic        done_ack, done_timeout;

    // Only rd is taken from the instruction word.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{i_inst[31:12], i_inst[6:0]};

    assign off  = i_alu_result[1:0];
    assign mode = i_load_store_mode;

    assign is_load      = i_valid & ~i_mem_rw & (i_wb_sel == 2'b00);
    assign is_store     = i_valid & i_mem_rw;
    assign is_mem       = is_load | is_store;
    assign illegal_mode = (mode == 3'b011) | (mode == 3'b110) | (mode == 3'b111);
    assign misaligned   = ((mode[1:0] == 2'b01) & off[0]) | ((mode == 3'b010) & (off != 2'b00));
    assign fault        = is_mem & (illegal_mode | misaligned);
    assign good_mem     = is_mem & ~fault;

    // Store lane placement; loads always enable the full word.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = i_data_2;
        if (is_store) begin
            case (mode[1:0])
                2'b00: begin
                    req_be    = 4'b0001 << off;
                    req_wdata = {4{i_data_2[7:0]}};
                end
                2'b01: begin
                    req_be    = off[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{i_data_2[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = i_data_2;
                end
            endcase
        end
    end

    always_comb begin
        case (i_wb_sel)
            2'b01:   alu_wb_data = i_alu_result;
            2'b10:   alu_wb_data = i_pc_inc;
            default: alu_wb_data = 32'h0;
        endcase
    end

    // Shift the addressed lane down, then extend according to the latched mode.
    always_comb begin
        logic [31:0] r;
        r = i_dmem_rdata >> {off_q, 3'b000};
        case (mode_q)
            3'b000:  load_data = {{24{r[7]}}, r[7:0]};
            3'b100:  load_data = {24'h0, r[7:0]};
            3'b001:  load_data = {{16{r[15]}}, r[15:0]};
            3'b101:  load_data = {16'h0, r[15:0]};
            default: load_data = r;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        o_stall      = 1'b0;
        accept_good  = 1'b0;
        accept_fault = 1'b0;
        accept_other = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (good_mem) begin
                    accept_good = 1'b1;
                    o_stall     = 1'b1;
                    state_d     = ST_WAIT;
                end else if (fault) begin
                    accept_fault = 1'b1;
                end else if (i_valid) begin
                    accept_other = 1'b1;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                // An ack in the final allowed cycle still wins over the timeout.
                if (i_dmem_ack) begin
                    done_ack = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    done_timeout = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are gated by state so reset drops them without waiting for a clock.
    assign o_dmem_req   = (state_q == ST_WAIT);
    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_be    = o_dmem_req ? be_q : 4'b0000;
    assign o_dmem_addr  = o_dmem_req ? addr_q : 32'h0;
    assign o_dmem_wdata = o_dmem_req ? wdata_q : 32'h0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q   <= 8'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            we_q    <= 1'b0;
            mode_q  <= 3'b000;
            off_q   <= 2'b00;
            rd_q    <= 5'd0;
            wr_en_q <= 1'b0;
        end else if (accept_good) begin
            cnt_q   <= 8'h0;
            addr_q  <= {i_alu_result[31:2], 2'b00};
            wdata_q <= req_wdata;
            be_q    <= req_be;
            we_q    <= is_store;
            mode_q  <= mode;
            off_q   <= off;
            rd_q    <= i_inst[11:7];
            wr_en_q <= i_reg_wr_en;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_wb_data      <= 32'h0;
            o_wb_rd        <= 5'd0;
            o_wb_reg_wr_en <= 1'b0;
            o_access_fault <= 1'b0;
            o_bus_err      <= 1'b0;
        end else begin
            o_valid        <= 1'b0;
            o_access_fault <= 1'b0;
            o_bus_err      <= 1'b0;
            if (accept_other) begin
                o_valid        <= 1'b1;
                o_wb_data      <= alu_wb_data;
                o_wb_rd        <= i_inst[11:7];
                o_wb_reg_wr_en <= i_reg_wr_en;
            end else if (accept_fault) begin
                o_valid        <= 1'b1;
                o_access_fault <= 1'b1;
                o_wb_data      <= 32'h0;
                o_wb_rd        <= i_inst[11:7];
                o_wb_reg_wr_en <= 1'b0;
            end else if (done_ack) begin
                o_valid        <= 1'b1;
                o_wb_data      <= we_q ? 32'h0 : load_data;
                o_wb_rd        <= rd_q;
                o_wb_reg_wr_en <= wr_en_q & ~we_q;
            end else if (done_timeout) begin
                o_valid        <= 1'b1;
                o_bus_err      <= 1'b1;
                o_wb_data      <= 32'h0;
                o_wb_rd        <= rd_q;
                o_wb_reg_wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, store lanes, load formatting,
// access faults, bus timeout and reset in the middle of a transaction.
module tb_mem_access_stage;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_inst;
    logic [31:0] i_alu_result;
    logic [31:0] i_data_2;
    logic        i_mem_rw;
    logic [2:0]  i_load_store_mode;
    logic [1:0]  i_wb_sel;
    logic [31:0] i_pc_inc;
    logic        i_reg_wr_en;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_wr_en;
    logic        o_access_fault;
    logic        o_bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_stall, obs_req;
    logic        obs_valid, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_inst(i_inst),
        .i_alu_result(i_alu_result), .i_data_2(i_data_2), .i_mem_rw(i_mem_rw),
        .i_load_store_mode(i_load_store_mode), .i_wb_sel(i_wb_sel), .i_pc_inc(i_pc_inc),
        .i_reg_wr_en(i_reg_wr_en), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
        .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_valid(o_valid), .o_wb_data(o_wb_data), .o_wb_rd(o_wb_rd),
        .o_wb_reg_wr_en(o_wb_reg_wr_en), .o_access_fault(o_access_fault), .o_bus_err(o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        i_valid = 0; i_inst = 0; i_alu_result = 0; i_data_2 = 0; i_mem_rw = 0;
        i_load_store_mode = 0; i_wb_sel = 0; i_pc_inc = 0; i_reg_wr_en = 0;
        i_dmem_ack = 0; i_dmem_rdata = 0;
    endtask

    // Drive one packet at a negedge; returns at the negedge where o_valid is seen.
    task automatic mem_op(input logic st, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] data, input int ack_at, input logic [31:0] rdata);
        int wait_cycle;
        i_valid = 1; i_mem_rw = st; i_wb_sel = 2'b00; i_load_store_mode = mode;
        i_alu_result = addr; i_data_2 = data; i_inst = 32'(7) << 7; i_reg_wr_en = 1;
        obs_stall = 0; obs_req = 0; obs_valid = 0; wait_cycle = 0;
        obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_stall) obs_stall++;
            if (o_dmem_req) begin
                obs_req++;
                wait_cycle++;
                if (wait_cycle == 1) begin
                    obs_addr = o_dmem_addr; obs_wdata = o_dmem_wdata;
                    obs_be = o_dmem_be; obs_we = o_dmem_we;
                end
                i_dmem_ack   = (wait_cycle == ack_at);
                i_dmem_rdata = rdata;
            end
            @(negedge clk);
            i_valid = 0; i_dmem_ack = 0;
            if (o_valid) begin
                obs_valid = 1;
                break;
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_req", 32'(o_dmem_req), 32'd0);
        check("reset_stall", 32'(o_stall), 32'd0);
        check("reset_wb_data", o_wb_data, 32'h0);
        rst_n = 1;
        @(negedge clk);

        // ALU op
        i_valid = 1; i_wb_sel = 2'b01; i_alu_result = 32'h1234; i_inst = 32'(5) << 7; i_reg_wr_en = 1;
        #1 check("alu_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        i_valid = 0;
        check("alu_valid", 32'(o_valid), 32'd1);
        check("alu_data", o_wb_data, 32'h1234);
        check("alu_rd", 32'(o_wb_rd), 32'd5);
        check("alu_wr_en", 32'(o_wb_reg_wr_en), 32'd1);
        check("alu_stall2", 32'(o_stall), 32'd0);
        @(negedge clk);
        check("alu_valid_pulse", 32'(o_valid), 32'd0);

        // pc+4 select
        i_valid = 1; i_wb_sel = 2'b10; i_pc_inc = 32'h0000_0444; i_inst = 32'(9) << 7;
        @(negedge clk);
        i_valid = 0;
        check("pc4_data", o_wb_data, 32'h444);
        check("pc4_rd", 32'(o_wb_rd), 32'd9);

        // SB at offset 3, ack in third wait cycle
        mem_op(1, 3'b000, 32'h103, 32'hAABBCCDD, 3, 32'h0);
        check("sb_addr", obs_addr, 32'h100);
        check("sb_be", 32'(obs_be), 32'h8);
        check("sb_wdata", obs_wdata, 32'hDDDDDDDD);
        check("sb_we", 32'(obs_we), 32'd1);
        check("sb_stall_cycles", 32'(obs_stall), 32'd4);
        check("sb_req_cycles", 32'(obs_req), 32'd3);
        check("sb_valid", 32'(obs_valid), 32'd1);
        check("sb_wr_en", 32'(o_wb_reg_wr_en), 32'd0);
        check("sb_fault", 32'(o_access_fault | o_bus_err), 32'd0);

        // SH at offset 2
        mem_op(1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0);
        check("sh_be", 32'(obs_be), 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCDABCD);
        check("sh_addr", obs_addr, 32'h200);

        // Loads
        mem_op(0, 3'b000, 32'h101, 32'h0, 1, 32'h0000_8000);
        check("lb_data", o_wb_data, 32'hFFFFFF80);
        check("lb_wr_en", 32'(o_wb_reg_wr_en), 32'd1);
        check("lb_rd", 32'(o_wb_rd), 32'd7);
        check("lb_be", 32'(obs_be), 32'hF);
        check("lb_we", 32'(obs_we), 32'd0);
        check("lb_stall_cycles", 32'(obs_stall), 32'd2);
        mem_op(0, 3'b100, 32'h101, 32'h0, 1, 32'h0000_8000);
        check("lbu_data", o_wb_data, 32'h00000080);
        mem_op(0, 3'b001, 32'h102, 32'h0, 1, 32'h8001_0000);
        check("lh_data", o_wb_data, 32'hFFFF8001);
        mem_op(0, 3'b101, 32'h102, 32'h0, 2, 32'h8001_0000);
        check("lhu_data", o_wb_data, 32'h00008001);
        mem_op(0, 3'b010, 32'h104, 32'h0, 1, 32'h1234_5678);
        check("lw_data", o_wb_data, 32'h12345678);
        check("lw_addr", obs_addr, 32'h104);

        // Misaligned LW
        mem_op(0, 3'b010, 32'h102, 32'h0, 1, 32'h0);
        check("lw_mis_req", 32'(obs_req), 32'd0);
        check("lw_mis_stall", 32'(obs_stall), 32'd0);
        check("lw_mis_valid", 32'(obs_valid), 32'd1);
        check("lw_mis_fault", 32'(o_access_fault), 32'd1);
        check("lw_mis_wr_en", 32'(o_wb_reg_wr_en), 32'd0);
        @(negedge clk);
        check("fault_pulse", 32'(o_access_fault), 32'd0);

        // Illegal mode on a store
        mem_op(1, 3'b110, 32'h100, 32'h0, 1, 32'h0);
        check("illegal_req", 32'(obs_req), 32'd0);
        check("illegal_fault", 32'(o_access_fault), 32'd1);

        // Ack outside WAIT is ignored
        i_dmem_ack = 1;
        @(negedge clk);
        i_dmem_ack = 0;
        check("stray_ack_valid", 32'(o_valid), 32'd0);

        // Timeout
        mem_op(0, 3'b010, 32'h200, 32'h0, 0, 32'h0);
        check("to_req_cycles", 32'(obs_req), 32'd4);
        check("to_stall_cycles", 32'(obs_stall), 32'd5);
        check("to_valid", 32'(obs_valid), 32'd1);
        check("to_bus_err", 32'(o_bus_err), 32'd1);
        check("to_wr_en", 32'(o_wb_reg_wr_en), 32'd0);
        i_valid = 1; i_wb_sel = 2'b01; i_alu_result = 32'h5555; i_inst = 32'(3) << 7; i_reg_wr_en = 1;
        @(negedge clk);
        i_valid = 0;
        check("to_bus_err_pulse", 32'(o_bus_err), 32'd0);
        check("after_to_data", o_wb_data, 32'h5555);

        // Reset in WAIT
        i_valid = 1; i_mem_rw = 1; i_load_store_mode = 3'b010; i_alu_result = 32'h300;
        i_data_2 = 32'h11112222;
        @(negedge clk);
        i_valid = 0;
        #1 check("rw_req_before", 32'(o_dmem_req), 32'd1);
        #1 rst_n = 0;
        #1;
        check("rw_req", 32'(o_dmem_req), 32'd0);
        check("rw_we", 32'(o_dmem_we), 32'd0);
        check("rw_be", 32'(o_dmem_be), 32'd0);
        check("rw_stall", 32'(o_stall), 32'd0);
        check("rw_wb_data", o_wb_data, 32'h0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_op(1, 3'b010, 32'h300, 32'hCAFEF00D, 1, 32'h0);
        check("sw_be", 32'(obs_be), 32'hF);
        check("sw_wdata", obs_wdata, 32'hCAFEF00D);
        check("sw_stall_cycles", 32'(obs_stall), 32'd2);
        check("sw_valid", 32'(obs_valid), 32'd1);
        check("sw_wr_en", 32'(o_wb_reg_wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
